// File: rtl/hamming_arb_pkg.sv
// Shared types and width helpers for the HammingWeight sharing arbiter.
// Provides the sequencer state encoding and the derived-width functions
// used by both the top level and the round-robin picker.
package hamming_arb_pkg;

  // Operand width of the shared HammingWeight unit in the IDP datapath.
  localparam int DEF_DATA_W = 16;

  // Sequencer states: arbitrate, issue start, wait for result, return result.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  // Requester index width; at least one bit even for a single requester.
  function automatic int id_w_f(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width needed to hold a population count of a w-bit word (0..w).
  function automatic int hw_w_f(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/hamming_share_arb_rr_pick.sv
// Combinational round-robin picker.
// Searches the request vector starting at ptr and wrapping past the top
// index; returns the first requester found as a one-hot grant and as a
// binary index. An empty request vector yields an all-zero grant.
module rr_pick
  import hamming_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_w_f(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx
);

  logic found;

  // Two passes: first the indices at or above the pointer, then wrap to 0.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && req[j] && (j >= int'(ptr))) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = ID_W'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/hamming_share_arb.sv
// Round-robin arbiter/sequencer sharing one HammingWeight unit between
// NUM_REQ requesters. One operand is accepted per operation, handed to the
// unit with a one-cycle hw_op_start, and the weight is returned tagged with
// the requester index once hw_vld arrives.
//
// Optional feature (macro HAMMING_ARB_TIMEOUT_EN): adds rsp_err and a WAIT
// cycle counter; if the unit stays silent for TIMEOUT_CYC cycles the
// operation is answered with rsp_err=1 and rsp_hamw=0.
module hamming_share_arb
  import hamming_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = DEF_DATA_W,
`ifdef HAMMING_ARB_TIMEOUT_EN
  parameter int TIMEOUT_CYC = 16,
`endif
  localparam int ID_W       = id_w_f(NUM_REQ),
  localparam int HW_W       = hw_w_f(DATA_W)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_din,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic                      rsp_vld,
  output logic [ID_W-1:0]           rsp_id,
  output logic [HW_W-1:0]           rsp_hamw,
`ifdef HAMMING_ARB_TIMEOUT_EN
  output logic                      rsp_err,
`endif
  output logic                      busy,
  output logic                      hw_op_start,
  output logic [DATA_W-1:0]         hw_din,
  input  logic                      hw_vld,
  input  logic [HW_W-1:0]           hw_hamw
);

  arb_state_t          state_q;
  arb_state_t          state_d;
  logic [ID_W-1:0]     ptr_q;
  logic [ID_W-1:0]     id_q;
  logic [NUM_REQ-1:0]  grant_w;
  logic [ID_W-1:0]     pick_idx;
  logic [DATA_W-1:0]   din_sel;
  logic                go_start;
  logic                go_resp;
  logic                tmo_hit;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .grant (grant_w),
    .idx   (pick_idx)
  );

  // Operand of the current winner, selected by its one-hot grant.
  always_comb begin
    din_sel = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (grant_w[j]) begin
        din_sel = req_din[j*DATA_W +: DATA_W];
      end
    end
  end

`ifdef HAMMING_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo_cnt;

  // Counts WAIT cycles; held at zero elsewhere so every WAIT starts from 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state_q == ST_WAIT) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end else begin
      tmo_cnt <= '0;
    end
  end

  // A result arriving on the last allowed cycle still wins over the abort.
  assign tmo_hit = (state_q == ST_WAIT) && !hw_vld &&
                   (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // Sequencer next state plus the two transition strobes used by the
  // registered output logic.
  always_comb begin
    state_d  = state_q;
    go_start = 1'b0;
    go_resp  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d  = ST_START;
          go_start = 1'b1;
        end
      end
      ST_START: begin
        // hw_vld is deliberately not looked at here.
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (hw_vld || tmo_hit) begin
          state_d = ST_RESP;
          go_resp = 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant side: latch winner and operand, pulse ack and start for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ack     <= '0;
      hw_op_start <= 1'b0;
      hw_din      <= '0;
      id_q        <= '0;
    end else begin
      req_ack     <= go_start ? grant_w : '0;
      hw_op_start <= go_start;
      if (go_start) begin
        hw_din <= din_sel;
        id_q   <= pick_idx;
      end
    end
  end

  // Response side: one-cycle strobe; id and weight hold until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld  <= 1'b0;
      rsp_id   <= '0;
      rsp_hamw <= '0;
`ifdef HAMMING_ARB_TIMEOUT_EN
      rsp_err  <= 1'b0;
`endif
    end else begin
      rsp_vld <= go_resp;
      if (go_resp) begin
        rsp_id   <= id_q;
        rsp_hamw <= hw_vld ? hw_hamw : '0;
`ifdef HAMMING_ARB_TIMEOUT_EN
        rsp_err  <= !hw_vld;
`endif
      end
    end
  end

  // Round-robin pointer moves just past the requester that was served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (state_q == ST_RESP) begin
      ptr_q <= (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
    end
  end

  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hamming_share_arb.sv
// Self-checking bench for hamming_share_arb: directed vector table,
// hand-written multi-cycle sequences, and a randomized phase checked
// against a transaction-level reference model.
`timescale 1ns/1ps
module tb_hamming_share_arb;
  import hamming_arb_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 16;
  localparam int ID_W    = 2;
  localparam int HW_W    = 5;
  localparam int TMO     = 16;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic [NUM_REQ-1:0]        req = '0;
  logic [NUM_REQ*DATA_W-1:0] req_din = '0;
  logic [NUM_REQ-1:0]        req_ack;
  logic                      rsp_vld;
  logic [ID_W-1:0]           rsp_id;
  logic [HW_W-1:0]           rsp_hamw;
  logic                      busy;
  logic                      hw_op_start;
  logic [DATA_W-1:0]         hw_din;
  logic                      hw_vld = 1'b0;
  logic [HW_W-1:0]           hw_hamw = '0;
`ifdef HAMMING_ARB_TIMEOUT_EN
  logic                      rsp_err;
`endif

  hamming_share_arb #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W)
`ifdef HAMMING_ARB_TIMEOUT_EN
    ,.TIMEOUT_CYC (TMO)
`endif
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_din     (req_din),
    .req_ack     (req_ack),
    .rsp_vld     (rsp_vld),
    .rsp_id      (rsp_id),
    .rsp_hamw    (rsp_hamw),
`ifdef HAMMING_ARB_TIMEOUT_EN
    .rsp_err     (rsp_err),
`endif
    .busy        (busy),
    .hw_op_start (hw_op_start),
    .hw_din      (hw_din),
    .hw_vld      (hw_vld),
    .hw_hamw     (hw_hamw)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive point: just after the rising edge. Sample point: falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    req = '0; req_din = '0; hw_vld = 1'b0; hw_hamw = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"},   32'(req_ack),     32'(0));
    chk({tag, "_rvld"},  32'(rsp_vld),     32'(0));
    chk({tag, "_rid"},   32'(rsp_id),      32'(0));
    chk({tag, "_rhamw"}, 32'(rsp_hamw),    32'(0));
    chk({tag, "_busy"},  32'(busy),        32'(0));
    chk({tag, "_start"}, 32'(hw_op_start), 32'(0));
    chk({tag, "_din"},   32'(hw_din),      32'(0));
`ifdef HAMMING_ARB_TIMEOUT_EN
    chk({tag, "_err"},   32'(rsp_err),     32'(0));
`endif
  endtask

  // Runs one operation from the drive point of an IDLE cycle: waits for the
  // ack, acts as the HammingWeight unit with hw_vld 'lat' cycles after the
  // START cycle, and returns what the response carried. Requesters in
  // 'keep' keep requesting after their ack; others drop their request.
  task automatic serve(input int lat, input logic [NUM_REQ-1:0] keep, input bit noise,
                       output int id, output int hamw, output int din, output int ack_cyc);
    logic [NUM_REQ-1:0] ack_v;
    logic [DATA_W-1:0]  din_seen;
    bit got;
    int id_ack;
    id = -1; hamw = -1; din = -1; ack_cyc = -1; got = 1'b0;
    ack_v = '0; din_seen = '0; id_ack = -1;
    for (int k = 0; k < 40 && !got; k++) begin
      hw_vld  = noise;
      hw_hamw = noise ? '1 : '0;
      smp();
      if (req_ack != '0) got = 1'b1;
      else step();
    end
    chk("ack_wait", 32'(got), 32'(1));
    if (!got) begin
      hw_vld = 1'b0;
      return;
    end
    ack_v = req_ack; din_seen = hw_din; ack_cyc = cyc;
    chk("ack_onehot", 32'($onehot(req_ack)), 32'(1));
    chk("start_with_ack", 32'(hw_op_start), 32'(1));
    chk("busy_start", 32'(busy), 32'(1));
    for (int i = 0; i < NUM_REQ; i++) if (ack_v[i]) id_ack = i;
    step();
    hw_vld = 1'b0;
    req = req & (~ack_v | keep);
    for (int j = 1; j <= lat; j++) begin
      if (j == lat) begin
        hw_vld  = 1'b1;
        hw_hamw = HW_W'($countones(hw_din));
      end
      smp();
      chk("din_hold", 32'(hw_din), 32'(din_seen));
      chk("start_single", 32'(hw_op_start), 32'(0));
      chk("ack_single", 32'(req_ack), 32'(0));
      chk("rsp_early", 32'(rsp_vld), 32'(0));
      step();
      hw_vld = 1'b0;
    end
    smp();
    chk("rsp_vld", 32'(rsp_vld), 32'(1));
    chk("rsp_id_vs_ack", 32'(rsp_id), 32'(id_ack));
    chk("din_hold_resp", 32'(hw_din), 32'(din_seen));
`ifdef HAMMING_ARB_TIMEOUT_EN
    chk("rsp_err_normal", 32'(rsp_err), 32'(0));
`endif
    id = int'(rsp_id); hamw = int'(rsp_hamw); din = int'(din_seen);
    step();
  endtask

  typedef struct {
    int                id;
    logic [DATA_W-1:0] din;
    int                lat;
    bit                noise;
    int                exp_hamw;
  } vec_t;

  vec_t tbl [6];

  // Reference model state for the randomized phase.
  bit                 m_act;
  int                 m_ptr, m_id, t_dec, t_vld;
  logic [DATA_W-1:0]  m_dat;
  logic [NUM_REQ-1:0] r_lvl, e_ack, e_ack_prev;
  logic [DATA_W-1:0]  r_dat [NUM_REQ];

  initial begin
    int id, hamw, din, ac, prev_ac, prev_lat, w;
    bit got, e_start, e_busy, e_rsp;
    int exp4 [4];
    int fair [5];

    tbl[0] = '{0, 16'h0001, 1, 1'b0, 1};
    tbl[1] = '{2, 16'd27834, 3, 1'b1, 9};
    tbl[2] = '{3, 16'hFFFF, 2, 1'b0, 16};
    tbl[3] = '{1, 16'h0000, 4, 1'b1, 0};
    tbl[4] = '{0, 16'h8001, 1, 1'b1, 2};
    tbl[5] = '{2, 16'hA5A5, 2, 1'b0, 8};

    // Reset state
    do_reset();
    smp();
    chk_all_zero("reset");
    step();

    // Table of single-requester transactions
    for (int t = 0; t < 6; t++) begin
      req_din = {$urandom, $urandom};
      req_din[tbl[t].id*DATA_W +: DATA_W] = tbl[t].din;
      req = '0;
      req[tbl[t].id] = 1'b1;
      serve(tbl[t].lat, '0, tbl[t].noise, id, hamw, din, ac);
      chk($sformatf("tbl%0d_id", t), 32'(id), 32'(tbl[t].id));
      chk($sformatf("tbl%0d_hamw", t), 32'(hamw), 32'(tbl[t].exp_hamw));
      chk($sformatf("tbl%0d_din", t), 32'(din), 32'(tbl[t].din));
    end

    // All four requesting at once after reset: order 0,1,2,3
    do_reset();
    exp4 = '{16, 0, 8, 2};
    req_din = {16'h8001, 16'h00FF, 16'h0000, 16'hFFFF};
    req = 4'hF;
    for (int k = 0; k < 4; k++) begin
      serve(1 + k, '0, 1'b0, id, hamw, din, ac);
      chk($sformatf("all4_%0d_id", k), 32'(id), 32'(k));
      chk($sformatf("all4_%0d_hamw", k), 32'(hamw), 32'(exp4[k]));
    end

    // Fairness: req[1] held, req[3] joins after the first ack
    fair = '{1, 3, 1, 3, 1};
    req_din = {16'h0007, 16'h0, 16'h0F0F, 16'h0};
    req = 4'b0010;
    prev_ac = -1; prev_lat = 0;
    for (int k = 0; k < 5; k++) begin
      serve(2 + (k % 2), 4'b1010, 1'b0, id, hamw, din, ac);
      chk($sformatf("fair%0d_id", k), 32'(id), 32'(fair[k]));
      chk($sformatf("fair%0d_hamw", k), 32'(hamw), 32'((fair[k] == 1) ? 8 : 3));
      if (prev_ac >= 0) chk($sformatf("fair%0d_gap", k), 32'(ac - prev_ac), 32'(prev_lat + 3));
      prev_ac = ac; prev_lat = 2 + (k % 2);
      if (k == 0) req = req | 4'b1000;
    end
    req = '0;
    step();

    // Single requester back-to-back, then pointer wrap from 3 to 0
    req_din = {16'h3003, 16'h0, 16'h0, 16'h0001};
    req = 4'b1000;
    prev_ac = -1;
    for (int k = 0; k < 3; k++) begin
      serve(1, 4'b1000, 1'b1, id, hamw, din, ac);
      chk($sformatf("solo%0d_id", k), 32'(id), 32'(3));
      chk($sformatf("solo%0d_hamw", k), 32'(hamw), 32'(4));
      if (prev_ac >= 0) chk($sformatf("solo%0d_gap", k), 32'(ac - prev_ac), 32'(4));
      prev_ac = ac;
    end
    req = 4'b1001;
    serve(2, 4'b1000, 1'b0, id, hamw, din, ac);
    chk("wrap_id0", 32'(id), 32'(0));
    chk("wrap_hamw0", 32'(hamw), 32'(1));
    serve(2, '0, 1'b0, id, hamw, din, ac);
    chk("wrap_id3", 32'(id), 32'(3));

    // Reset during WAIT, stale hw_vld afterwards
    req_din = {16'h0, 16'h0, 16'h0, 16'h00F0};
    req = 4'b0001;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      smp();
      if (req_ack != '0) got = 1'b1;
      else step();
    end
    chk("rstwait_ack", 32'(got), 32'(1));
    step();
    req = '0;
    step();
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    step();
    rst_n = 1'b1;
    hw_vld = 1'b1;
    hw_hamw = 5'd7;
    for (int k = 0; k < 5; k++) begin
      smp();
      chk("stale_rvld", 32'(rsp_vld), 32'(0));
      chk("stale_busy", 32'(busy), 32'(0));
      step();
      hw_vld = 1'b0;
    end

`ifdef HAMMING_ARB_TIMEOUT_EN
    // Unit never answers: abort exactly TMO cycles after WAIT entry
    req = 4'b0001;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      smp();
      if (req_ack != '0) got = 1'b1;
      else step();
    end
    chk("tmo_ack", 32'(got), 32'(1));
    step();
    req = '0;
    for (int k = 1; k <= TMO; k++) begin
      smp();
      chk("tmo_early", 32'(rsp_vld), 32'(0));
      step();
    end
    smp();
    chk("tmo_rvld", 32'(rsp_vld), 32'(1));
    chk("tmo_err", 32'(rsp_err), 32'(1));
    chk("tmo_hamw", 32'(rsp_hamw), 32'(0));
    chk("tmo_id", 32'(rsp_id), 32'(0));
    step();
    smp();
    chk("tmo_after_rvld", 32'(rsp_vld), 32'(0));
    chk("tmo_after_busy", 32'(busy), 32'(0));
    step();
`endif

    // Randomized traffic against the transaction-level model
    do_reset();
    m_act = 1'b0; m_ptr = 0; m_id = 0; t_dec = 0; t_vld = 0; m_dat = '0;
    r_lvl = '0; e_ack_prev = '0;
    for (int i = 0; i < NUM_REQ; i++) r_dat[i] = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (e_ack_prev[i]) r_lvl[i] = 1'b0;
        else if (r_lvl[i]) begin
          if ($urandom_range(0, 15) == 0) r_lvl[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          r_lvl[i] = 1'b1;
          case ($urandom_range(0, 5))
            0:       r_dat[i] = '0;
            1:       r_dat[i] = '1;
            default: r_dat[i] = DATA_W'($urandom);
          endcase
        end
      end
      req = r_lvl;
      for (int i = 0; i < NUM_REQ; i++) req_din[i*DATA_W +: DATA_W] = r_dat[i];
      if (m_act && c == t_vld) begin
        hw_vld = 1'b1; hw_hamw = HW_W'($countones(hw_din));
      end else if (m_act && c >= t_dec + 2) begin
        hw_vld = 1'b0; hw_hamw = HW_W'($urandom);
      end else begin
        hw_vld = ($urandom_range(0, 3) == 0); hw_hamw = HW_W'($urandom);
      end
      smp();
      e_start = m_act && (c == t_dec + 1);
      e_busy  = m_act && (c >= t_dec + 1);
      e_rsp   = m_act && (c == t_vld + 1);
      e_ack   = e_start ? NUM_REQ'(1 << m_id) : '0;
      chk("rnd_ack", 32'(req_ack), 32'(e_ack));
      chk("rnd_start", 32'(hw_op_start), 32'(e_start));
      chk("rnd_busy", 32'(busy), 32'(e_busy));
      chk("rnd_rvld", 32'(rsp_vld), 32'(e_rsp));
      if (e_busy) chk("rnd_din", 32'(hw_din), 32'(m_dat));
      if (e_rsp) begin
        chk("rnd_rid", 32'(rsp_id), 32'(m_id));
        chk("rnd_rhamw", 32'(rsp_hamw), 32'($countones(m_dat)));
`ifdef HAMMING_ARB_TIMEOUT_EN
        chk("rnd_rerr", 32'(rsp_err), 32'(0));
`endif
      end
      if (e_rsp) begin
        m_act = 1'b0;
        m_ptr = (m_id + 1) % NUM_REQ;
      end else if (!m_act && req != '0) begin
        w = -1;
        for (int k = 0; k < NUM_REQ; k++)
          if (w < 0 && req[(m_ptr + k) % NUM_REQ]) w = (m_ptr + k) % NUM_REQ;
        m_act = 1'b1; m_id = w; m_dat = r_dat[w];
        t_dec = c; t_vld = c + 1 + int'($urandom_range(1, 4));
      end
      e_ack_prev = e_ack;
      step();
    end
    req = '0; hw_vld = 1'b0;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached (compared %0d)", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hamming_share_arb.md
Name: hamming_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one HammingWeight unit between NUM_REQ requesters.
- Accepts one 16-bit word from the winning requester and drives the unit's op_start/din.
- Waits for hw_vld, then returns the 5-bit weight tagged with the requester ID.
- Sits between requester-side logic and the single HammingWeight instance in the IDP datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 16, operand width; must match the HammingWeight unit.
- TIMEOUT_CYC, 16, cycles in WAIT before timeout abort (used only with the optional feature).
- Derived localparams: ID_W = max(1, clog2(NUM_REQ)); HW_W = clog2(DATA_W+1) = 5.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester request level; held until matching ack.
- req_din  in  NUM_REQ*DATA_W  packed operands; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ack  out  NUM_REQ  one-hot, one-cycle accept pulse.
- rsp_vld  out  1  one-cycle result strobe.
- rsp_id  out  ID_W  index of the requester that owns the result.
- rsp_hamw  out  HW_W  Hamming weight result.
- busy  out  1  high whenever state is not IDLE.
- hw_op_start  out  1  start pulse to the HammingWeight unit.
- hw_din  out  DATA_W  operand to the HammingWeight unit.
- hw_vld  in  1  result-valid from the HammingWeight unit.
- hw_hamw  in  HW_W  result from the HammingWeight unit.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0; state=IDLE.
  - RR pointer=0; internal ID/result registers 0.
- FSM states: IDLE, START, WAIT, RESP.
- IDLE:
  - If |req, select the winner by round robin, searching from the pointer upward with wrap.
  - On the same edge: latch req_din[winner] into hw_din, latch the ID, go to START.
  - req_ack[winner]=1 for exactly the START cycle; registered, so it appears the cycle after the decision.
- START:
  - hw_op_start=1 for exactly this cycle.
  - Go to WAIT unconditionally.
- WAIT:
  - hw_op_start=0.
  - On hw_vld=1, capture hw_hamw and go to RESP.
  - hw_din stays stable from START through RESP.
- RESP:
  - rsp_vld=1, rsp_id=latched ID, rsp_hamw=captured value, all for one cycle.
  - Pointer <= (ID+1) mod NUM_REQ.
  - Return to IDLE.
- rsp_id and rsp_hamw hold their last value after RESP; they are meaningful only while rsp_vld=1.
- Latency: grant decision -> op_start is 1 cycle; hw_vld -> rsp_vld is 1 cycle.
- Throughput: one operation per (unit latency + 3) cycles; a new arbitration happens in the IDLE cycle after RESP.
- Boundary conditions:
  - req dropped before ack: no ack and no operation. A request already latched completes regardless.
  - Multiple simultaneous reqs: exactly one ack. Repeated requests from one source cannot starve the others (RR fairness).
  - Single requester continuously requesting: served back-to-back, pointer wraps correctly.
  - hw_vld outside WAIT: ignored, no state change.
  - hw_vld in the same cycle as START: ignored; only WAIT samples hw_vld.
  - Reset mid-operation: abort immediately to IDLE; a later stale hw_vld is ignored because the FSM is not in WAIT.
- Width rule: rsp_hamw is an exact copy of hw_hamw; no arithmetic in this block.

Optional Feature:
- Macro: HAMMING_ARB_TIMEOUT_EN.
- Defined:
  - Adds output port rsp_err (1 bit, reset 0).
  - A WAIT-cycle counter starts at 0 on entry to WAIT.
  - If it reaches TIMEOUT_CYC without hw_vld: go to RESP with rsp_vld=1, rsp_err=1, rsp_hamw=0. Pointer advances as normal.
  - rsp_err=0 on normal responses.
- Undefined: no counter and no rsp_err port; WAIT waits indefinitely.

Decomposition:
- Package hamming_arb_pkg:
  - State enum (IDLE/START/WAIT/RESP).
  - HW_W and ID_W helper functions.
  - Default DATA_W=16.
- One natural sub-module, rr_pick: combinational round-robin picker.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant and binary index.

Test Plan:
- Reset then single req[0], din=16'h0001 -> ack[0] pulse, one hw_op_start pulse, rsp_vld with rsp_id=0, rsp_hamw=1.
- req[2], din=16'd27834 -> rsp_id=2, rsp_hamw=9; hw_din held at 16'd27834 until RESP.
- req[0..3] all asserted with din=16'hFFFF,16'h0000,16'h00FF,16'h8001 -> grant order 0,1,2,3; rsp_hamw=16,0,8,2.
- req[1] continuously asserted plus req[3] asserted after its first ack -> alternating grants 1,3,1,... with no starvation.
- rst_n pulsed low during WAIT, stale hw_vld injected afterwards -> all outputs 0, no rsp_vld.
- With HAMMING_ARB_TIMEOUT_EN, hw_vld withheld -> rsp_vld with rsp_err=1 and rsp_hamw=0 exactly TIMEOUT_CYC=16 cycles after WAIT entry.
